// File: rtl/prover_round_ctrl.sv
// prover_round_ctrl: drives one sumcheck proof through the prover, streaming each
// round's coefficients out and feeding the returned challenge back in.
`ifndef F_NBITS
`define F_NBITS 64
`endif

module prover_round_ctrl #(
    parameter int NGATES  = 8,
    parameter int NINPUTS = 8,
    parameter int NINBITS = $clog2(NINPUTS),
    parameter int NROUNDS = 2*NINBITS + $clog2(NGATES)
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            start,
    output logic                            en,
    output logic                            restart,
    output logic                            comp_w0,
    output logic [`F_NBITS-1:0]             tau,
    input  logic                            ready_pulse,
    input  logic [1:0]                      ready_code,
    input  logic [(NINBITS+1)*`F_NBITS-1:0] buf_data,
    input  logic                            w0_ready_pulse,
    output logic                            coef_valid,
    input  logic                            coef_ready,
    output logic [`F_NBITS-1:0]             coef_data,
    output logic                            coef_last,
    input  logic                            tau_valid,
    output logic                            tau_ready,
    input  logic [`F_NBITS-1:0]             tau_in,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(NROUNDS+1)-1:0]    rounds,
    output logic [31:0]                     cycles,
    output logic                            err
);
    localparam int FW   = `F_NBITS;
    localparam int IDXW = $clog2(NINBITS + 1);
    localparam int RW   = $clog2(NROUNDS + 1);
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NINBITS);
    localparam logic [RW-1:0]   ROUNDS_MAX = RW'(NROUNDS);

    typedef enum logic [2:0] {
        S_IDLE, S_KICK, S_WAIT_ROUND, S_DRAIN, S_GET_TAU, S_ISSUE, S_WAIT_W0, S_DONE
    } state_t;

    state_t                 state;
    logic [NINBITS*FW-1:0]  buf_q;
    logic [IDXW-1:0]        idx;
    logic                   use_w0;
    logic [RW-1:0]          rounds_inc;
    logic                   final_code;
    logic                   at_max;

    always_comb begin
        rounds_inc = rounds + RW'(1);
        final_code = (ready_code >= 2'b10);
        at_max     = (rounds_inc == ROUNDS_MAX);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= S_IDLE;
            en         <= 1'b0;
            restart    <= 1'b0;
            comp_w0    <= 1'b0;
            tau        <= '0;
            coef_valid <= 1'b0;
            coef_data  <= '0;
            coef_last  <= 1'b0;
            tau_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rounds     <= '0;
            cycles     <= '0;
            err        <= 1'b0;
            buf_q      <= '0;
            idx        <= '0;
            use_w0     <= 1'b0;
        end else begin
            if (busy && cycles != '1)
                cycles <= cycles + 32'd1;
            if (ready_pulse && state != S_WAIT_ROUND)
                err <= 1'b1;
            if (w0_ready_pulse && state != S_WAIT_W0)
                err <= 1'b1;

            case (state)
                S_IDLE: if (start) begin
                    en      <= 1'b1;
                    restart <= 1'b1;
                    busy    <= 1'b1;
                    rounds  <= '0;
                    cycles  <= '0;
                    err     <= 1'b0;
                    state   <= S_KICK;
                end
                S_KICK: begin
                    en      <= 1'b0;
                    restart <= 1'b0;
                    state   <= S_WAIT_ROUND;
                end
                S_WAIT_ROUND: if (ready_pulse) begin
                    // entry 0 goes straight out; the rest are shifted down one per beat
                    coef_data  <= buf_data[FW-1:0];
                    buf_q      <= buf_data[(NINBITS+1)*FW-1:FW];
                    coef_valid <= 1'b1;
                    coef_last  <= 1'b0;
                    idx        <= '0;
                    rounds     <= rounds_inc;
                    use_w0     <= final_code || at_max;
                    if (final_code != at_max)
                        err <= 1'b1;
                    state      <= S_DRAIN;
                end
                S_DRAIN: if (coef_ready) begin
                    if (coef_last) begin
                        coef_valid <= 1'b0;
                        coef_last  <= 1'b0;
                        tau_ready  <= 1'b1;
                        state      <= S_GET_TAU;
                    end else begin
                        coef_data <= buf_q[FW-1:0];
                        buf_q     <= buf_q >> FW;
                        idx       <= idx + IDXW'(1);
                        coef_last <= ((idx + IDXW'(1)) == LAST_IDX);
                    end
                end
                S_GET_TAU: if (tau_valid) begin
                    tau       <= tau_in;
                    tau_ready <= 1'b0;
                    if (use_w0)
                        comp_w0 <= 1'b1;
                    else
                        en <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    en      <= 1'b0;
                    comp_w0 <= 1'b0;
                    state   <= use_w0 ? S_WAIT_W0 : S_WAIT_ROUND;
                end
                S_WAIT_W0: if (w0_ready_pulse) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prover_round_ctrl.sv
// tb_prover_round_ctrl: plays the prover, stream sink and challenge source around
// prover_round_ctrl and checks each proof against per-proof expectations.
`ifndef F_NBITS
`define F_NBITS 64
`endif

module tb_prover_round_ctrl;
    localparam int NINBITS = 3;
    localparam int NROUNDS = 9;
    localparam int NENT    = NINBITS + 1;
    localparam int FW      = `F_NBITS;

    logic                 clk = 1'b0;
    logic                 rstb, start, en, restart, comp_w0;
    logic [FW-1:0]        tau, coef_data, tau_in;
    logic                 ready_pulse, w0_ready_pulse, coef_valid, coef_ready, coef_last;
    logic [1:0]           ready_code;
    logic [NENT*FW-1:0]   buf_data;
    logic                 tau_valid, tau_ready, busy, done, err;
    logic [3:0]           rounds;
    logic [31:0]          cycles;

    always #5 clk = ~clk;

    prover_round_ctrl #(.NGATES(8), .NINPUTS(8)) dut (
        .clk(clk), .rstb(rstb), .start(start), .en(en), .restart(restart),
        .comp_w0(comp_w0), .tau(tau), .ready_pulse(ready_pulse), .ready_code(ready_code),
        .buf_data(buf_data), .w0_ready_pulse(w0_ready_pulse), .coef_valid(coef_valid),
        .coef_ready(coef_ready), .coef_data(coef_data), .coef_last(coef_last),
        .tau_valid(tau_valid), .tau_ready(tau_ready), .tau_in(tau_in), .busy(busy),
        .done(done), .rounds(rounds), .cycles(cycles), .err(err)
    );

    int vectors = 0;
    int miscompares = 0;
    int edge_no = 0;
    int cr_mode = 0;
    int n_en, n_restart, n_comp, n_done, n_pulse_bad, n_unstable, n_order_bad;
    logic p_en, p_restart, p_comp, p_done, p_stall, exp_tr;
    logic [FW-1:0] p_data;
    logic [FW-1:0] last_tau;
    logic [FW:0]   got_q[$];
    logic [FW:0]   exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle observation of the pulse outputs and the coefficient stream.
    task automatic monitor();
        if (!rstb) begin
            p_en = 1'b0; p_restart = 1'b0; p_comp = 1'b0; p_done = 1'b0;
            p_stall = 1'b0; exp_tr = 1'b0;
            return;
        end
        if (exp_tr)
            chk("tau_ready_after_last", 64'(tau_ready), 64'd1);
        exp_tr = 1'b0;
        n_en      += int'(en);
        n_restart += int'(restart);
        n_comp    += int'(comp_w0);
        n_done    += int'(done);
        if ((int'(en) + int'(comp_w0) + int'(done)) > 1 || (restart && !en) ||
            (en && p_en) || (restart && p_restart) || (comp_w0 && p_comp) || (done && p_done))
            n_pulse_bad++;
        if (p_stall && (coef_data !== p_data || coef_valid !== 1'b1))
            n_unstable++;
        if (tau_ready && coef_valid)
            n_order_bad++;
        if (coef_valid && coef_ready) begin
            got_q.push_back({coef_last, coef_data});
            if (coef_last) exp_tr = 1'b1;
        end
        p_stall = coef_valid && !coef_ready;
        p_data = coef_data;
        p_en = en; p_restart = restart; p_comp = comp_w0; p_done = done;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_no++;
        case (cr_mode)
            0:       coef_ready = 1'b1;
            1:       coef_ready = ~coef_ready;
            2:       coef_ready = 1'($urandom_range(0, 1));
            default: coef_ready = 1'b0;
        endcase
        @(negedge clk);
        monitor();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tau"}, 64'(tau), 64'd0);
        chk({tag, "_coef_data"}, 64'(coef_data), 64'd0);
        chk({tag, "_ctrl"}, 64'({en, restart, comp_w0, coef_valid, coef_last, tau_ready,
                                 busy, done, err, rounds, cycles}), 64'd0);
    endtask

    task automatic run_proof(input int last_round, input logic [1:0] last_code, input int mode,
                             input int stall_round, input int spur_round, input int busy_round);
        int k, w, to;
        logic [1:0] code;
        logic [FW-1:0] v;
        logic [NENT*FW-1:0] b;
        bit exp_err;
        exp_err = (last_code[1] != (last_round == NROUNDS)) || (spur_round != 0);
        n_en = 0; n_restart = 0; n_comp = 0; n_done = 0;
        n_pulse_bad = 0; n_unstable = 0; n_order_bad = 0;
        got_q.delete(); exp_q.delete();
        cr_mode = mode;

        start = 1'b1; tick(); k = edge_no; start = 1'b0;
        chk("kick_en", 64'(en), 64'd1);
        chk("kick_restart", 64'(restart), 64'd1);
        chk("kick_clear", 64'({err, rounds, cycles}), 64'd0);

        for (int r = 1; r <= last_round; r++) begin
            tick();
            if (r == busy_round) begin
                start = 1'b1; tick(); start = 1'b0;
                chk("busy_start_rounds", 64'(rounds), 64'(r - 1));
                chk("busy_start_cycles", 64'(cycles), 64'(edge_no - k));
            end
            repeat ($urandom_range(0, 3)) tick();
            code = (r == last_round) ? last_code : 2'($urandom_range(0, 1));
            for (int i = 0; i < NENT; i++) begin
                b[i*FW +: FW] = {$urandom, $urandom};
                exp_q.push_back({1'(i == NENT - 1), b[i*FW +: FW]});
            end
            ready_pulse = 1'b1; ready_code = code; buf_data = b;
            tick();
            chk("capture_valid", 64'(coef_valid), 64'd1);
            if (r == spur_round) begin
                buf_data = {NENT{$urandom, $urandom}};
                tick();
                chk("spurious_err", 64'(err), 64'd1);
            end
            ready_pulse = 1'b0;
            chk("capture_rounds", 64'(rounds), 64'(r));

            if (r == stall_round) begin
                tau_valid = 1'b0;
            end else begin
                v = {$urandom, $urandom};
                tau_in = v;
                tau_valid = 1'b1;
            end
            to = 0;
            while (!tau_ready && to < 100) begin
                tick();
                to++;
            end
            chk("tau_ready_wait", 64'(tau_ready), 64'd1);
            chk("tau_held", 64'(tau), 64'(last_tau));
            if (r == stall_round) begin
                repeat (20) tick();
                chk("stall_tau_ready", 64'(tau_ready), 64'd1);
                chk("stall_tau_held", 64'(tau), 64'(last_tau));
                v = 64'h1234_5678_9ABC_DEF0;
                tau_in = v;
                tau_valid = 1'b1;
            end
            tick();
            tau_valid = 1'b0;
            last_tau = v;
            chk("tau_latch", 64'(tau), 64'(v));
            chk("issue_en", 64'(en), 64'(r < last_round));
            chk("issue_w0", 64'(comp_w0), 64'(r == last_round));
        end

        repeat (1 + $urandom_range(0, 3)) tick();
        chk("w0_wait_busy", 64'(busy), 64'd1);
        w0_ready_pulse = 1'b1; tick(); w = edge_no; w0_ready_pulse = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("final_rounds", 64'(rounds), 64'(last_round));
        chk("final_err", 64'(err), 64'(exp_err));
        chk("final_cycles", 64'(cycles), 64'(w - k));
        tick();
        chk("done_single", 64'(done), 64'd0);
        tick();
        chk("cycles_frozen", 64'(cycles), 64'(w - k));

        chk("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("beat_data", 64'(got_q[i][FW-1:0]), 64'(exp_q[i][FW-1:0]));
            chk("beat_last", 64'(got_q[i][FW]), 64'(exp_q[i][FW]));
        end
        chk("en_pulses", 64'(n_en), 64'(last_round));
        chk("restart_pulses", 64'(n_restart), 64'd1);
        chk("w0_pulses", 64'(n_comp), 64'd1);
        chk("done_pulses", 64'(n_done), 64'd1);
        chk("pulse_rules", 64'(n_pulse_bad), 64'd0);
        chk("coef_stable", 64'(n_unstable), 64'd0);
        chk("tau_ready_order", 64'(n_order_bad), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        rstb = 1'b0; start = 1'b0; ready_pulse = 1'b0; ready_code = 2'b00;
        buf_data = '0; w0_ready_pulse = 1'b0; coef_ready = 1'b0;
        tau_valid = 1'b0; tau_in = '0; last_tau = '0;
        exp_tr = 1'b0; p_stall = 1'b0;
        repeat (2) tick();
        chk_reset_outputs("reset");
        rstb = 1'b1;
        tick();

        run_proof(NROUNDS, 2'b10 | 2'($urandom_range(0, 1)), 0, 0, 0, 0);  // nominal
        run_proof(NROUNDS, 2'b11, 1, 0, 0, 0);                              // 1010 backpressure
        run_proof(NROUNDS, 2'b10, 2, 1, 0, 2);                              // tau stall + start while busy
        run_proof(NROUNDS, 2'b10, 1, 0, 2, 0);                              // spurious ready_pulse
        run_proof(5, 2'b10, 0, 0, 0, 0);                                    // early final code
        run_proof(NROUNDS, 2'b01, 2, 0, 0, 0);                              // forced w0 at last round

        // abort a proof in DRAIN with err already set, then run a clean proof
        cr_mode = 3;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        ready_pulse = 1'b1; ready_code = 2'b00; buf_data = {NENT{$urandom, $urandom}};
        tick();
        tick();
        ready_pulse = 1'b0;
        chk("abort_err", 64'(err), 64'd1);
        chk("abort_in_drain", 64'(coef_valid), 64'd1);
        #2 rstb = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        last_tau = '0;
        repeat (3) tick();
        rstb = 1'b1;
        tick();
        chk("post_reset_idle", 64'(busy), 64'd0);
        run_proof(NROUNDS, 2'b10, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
